// File: rtl/flag_cond_eval.sv
// Flag register plus condition-code evaluator with a one-deep valid/ready response slot.
// Define FLAG_BYPASS_EN to forward same-cycle flag writes into evaluation instead of stalling.
module flag_cond_eval #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag_we,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             c_in,
   input  logic             v_in,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cond,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_taken,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t     state;
   logic [3:0] eval_flags;
   logic       fn, fz, fc, fv;
   logic       eval_taken;
   logic       accept, consume;

`ifdef FLAG_BYPASS_EN
   assign eval_flags = flag_we ? {n_in, z_in, c_in, v_in} : flags_q;
   assign req_ready  = rst & (!rsp_valid | rsp_ready);
`else
   // Stall acceptance during a flag write so evaluation never sees stale flags.
   assign eval_flags = flags_q;
   assign req_ready  = rst & (!rsp_valid | rsp_ready) & !flag_we;
`endif

   assign rsp_valid = (state == RESP);
   assign accept    = req_valid & req_ready;
   assign consume   = rsp_valid & rsp_ready;
   assign {fn, fz, fc, fv} = eval_flags;

   always_comb begin
      eval_taken = 1'b0;
      case (req_cond)
         4'h0: eval_taken = fz;
         4'h1: eval_taken = !fz;
         4'h2: eval_taken = fc;
         4'h3: eval_taken = !fc;
         4'h4: eval_taken = fn;
         4'h5: eval_taken = !fn;
         4'h6: eval_taken = fv;
         4'h7: eval_taken = !fv;
         4'h8: eval_taken = fc & !fz;
         4'h9: eval_taken = !fc | fz;
         4'hA: eval_taken = (fn == fv);
         4'hB: eval_taken = (fn != fv);
         4'hC: eval_taken = !fz & (fn == fv);
         4'hD: eval_taken = fz | (fn != fv);
         4'hE: eval_taken = 1'b1;
         default: eval_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rsp_taken <= 1'b0;
         rsp_tag   <= '0;
         flags_q   <= 4'h0;
         taken_cnt <= '0;
      end else begin
         if (flag_we) flags_q <= {n_in, z_in, c_in, v_in};
         if (consume && rsp_taken) taken_cnt <= taken_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RESP;
                  rsp_taken <= eval_taken;
                  rsp_tag   <= req_tag;
               end
            end
            RESP: begin
               if (accept) begin
                  rsp_taken <= eval_taken;
                  rsp_tag   <= req_tag;
               end else if (consume) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_cond_eval.sv
// Bench for flag_cond_eval: directed scenarios plus random traffic against a transaction-level model.
module tb_flag_cond_eval;
   localparam int TAG_W = 4;
   localparam int CNT_W = 4;
`ifdef FLAG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flag_we = 1'b0, z_in = 1'b0, n_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
   logic req_valid = 1'b0, req_ready;
   logic [3:0] req_cond = 4'h0;
   logic [TAG_W-1:0] req_tag = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_taken;
   logic [TAG_W-1:0] rsp_tag;
   logic [3:0] flags_q;
   logic [CNT_W-1:0] taken_cnt;

   int tests = 0;
   int fails = 0;

   // model state
   bit             m_valid, m_taken;
   bit [TAG_W-1:0] m_tag;
   bit [3:0]       m_flags;   // {N,Z,C,V}
   bit [CNT_W-1:0] m_cnt;

   flag_cond_eval #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flag_we(flag_we), .z_in(z_in), .n_in(n_in), .c_in(c_in), .v_in(v_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_taken(rsp_taken), .rsp_tag(rsp_tag),
      .flags_q(flags_q), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   // Odd codes are the negation of the preceding even code; pairs pick the base predicate.
   function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
      bit n, z, cf, v, p;
      {n, z, cf, v} = f;
      case (c / 2)
         0: p = z;
         1: p = cf;
         2: p = n;
         3: p = v;
         4: p = cf && !z;
         5: p = (n == v);
         6: p = !z && (n == v);
         default: p = 1'b1;
      endcase
      return (c % 2 == 1) ? !p : p;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_taken = 0; m_tag = '0; m_flags = 4'h0; m_cnt = '0;
   endtask

   // One clock cycle: drive, check at negedge, advance the model, return just after the next posedge.
   task automatic step(input bit we, input bit [3:0] nzcv, input bit rv, input bit [3:0] cond,
                       input bit [TAG_W-1:0] tag, input bit rr);
      bit e_ready, acc, cons;
      flag_we = we; {n_in, z_in, c_in, v_in} = nzcv;
      req_valid = rv; req_cond = cond; req_tag = tag; rsp_ready = rr;
      @(negedge clk);
      e_ready = rst && (!m_valid || rr) && (BYP || !we);
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
         chk("rsp_taken", rsp_taken, m_taken);
         chk("rsp_tag", rsp_tag, m_tag);
      end
      chk("flags_q", flags_q, m_flags);
      chk("taken_cnt", taken_cnt, m_cnt);
      acc  = rv && e_ready;
      cons = m_valid && rr;
      if (cons && m_taken) m_cnt = m_cnt + 1'b1;
      if (acc) begin
         m_valid = 1;
         m_taken = ref_cond(cond, (BYP && we) ? nzcv : m_flags);
         m_tag   = tag;
      end else if (cons) begin
         m_valid = 0;
      end
      if (we) m_flags = nzcv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      #3;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_taken", rsp_taken, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_flags", flags_q, 0);
      chk("rst_cnt", taken_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // EQ with Z=1, tag 3
      step(1, 4'b0100, 0, 4'h0, 0, 1);
      step(0, 4'b0000, 1, 4'h0, 3, 1);
      step(0, 4'b0000, 0, 4'h0, 0, 1);
      chk("eq_cnt_after", taken_cnt, 1);

      // N=1,V=0: GE LT GT LE back to back
      step(1, 4'b1000, 0, 4'h0, 0, 1);
      step(0, 4'b1000, 1, 4'hA, 1, 1);
      step(0, 4'b1000, 1, 4'hB, 2, 1);
      step(0, 4'b1000, 1, 4'hC, 3, 1);
      step(0, 4'b1000, 1, 4'hD, 4, 1);
      step(0, 4'b1000, 0, 4'h0, 0, 1);
      chk("sign_cnt_after", taken_cnt, 3);

      // Stall with flag writes toggling Z
      step(0, 4'b0000, 1, 4'h0, 5, 0);
      step(1, 4'b0100, 1, 4'h1, 6, 0);
      step(1, 4'b0000, 1, 4'h1, 6, 0);
      step(1, 4'b0100, 1, 4'h1, 6, 0);
      step(0, 4'b0000, 0, 4'h0, 0, 1);
      step(0, 4'b0000, 0, 4'h0, 0, 1);

      // EQ request colliding with a Z write
      step(1, 4'b0000, 0, 4'h0, 0, 1);
      step(1, 4'b0100, 1, 4'h0, 7, 1);
      step(0, 4'b0100, 1, 4'h0, 7, 1);
      step(0, 4'b0100, 0, 4'h0, 0, 1);

      // Reset while a response is pending
      step(1, 4'b1111, 1, 4'hE, 9, 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 0);
      chk("mid_rst_flags", flags_q, 0);
      chk("mid_rst_cnt", taken_cnt, 0);
      chk("mid_rst_tag", rsp_tag, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // Counter wrap: 16 AL responses, NV interleaved
      for (int i = 0; i < 16; i++) begin
         step(0, 4'b0000, 1, 4'hE, TAG_W'(i), 1);
         if (i % 5 == 0) step(0, 4'b0000, 1, 4'hF, TAG_W'(i), 1);
      end
      step(0, 4'b0000, 0, 4'h0, 0, 1);
      chk("wrap_cnt", taken_cnt, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 3), 4'($urandom), ($urandom_range(0, 9) < 6),
              4'($urandom), TAG_W'($urandom), ($urandom_range(0, 9) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/flag_cond_eval.md
FLAG_COND_EVAL -- requirements
Module: flag_cond_eval

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, width of the request/response tag passed through unchanged.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the taken-branch statistics counter.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port flag_we  input  1  flag write strobe from the ALU/TST unit.
REQ-006 Port z_in, n_in, c_in, v_in  input  1 each  flags written when flag_we=1.
REQ-007 Port req_valid  input  1  condition-evaluation request valid.
REQ-008 Port req_ready  output  1  request accepted on a clk edge with req_valid=1 and req_ready=1.
REQ-009 Port req_cond  input  4  condition code to evaluate.
REQ-010 Port req_tag  input  TAG_W  request tag.
REQ-011 Port rsp_valid  output  1  response valid.
REQ-012 Port rsp_ready  input  1  response consumed on a clk edge with rsp_valid=1 and rsp_ready=1.
REQ-013 Port rsp_taken  output  1  evaluated condition result.
REQ-014 Port rsp_tag  output  TAG_W  tag of the request that produced the response.
REQ-015 Port flags_q  output  4  committed flags {N,Z,C,V}.
REQ-016 Port taken_cnt  output  CNT_W  count of delivered responses with rsp_taken=1.

Function
REQ-017 Flags register SHALL load {n_in,z_in,c_in,v_in} on every clk edge with flag_we=1 and hold otherwise.
REQ-018 Condition codes SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-019 FSM SHALL have two states: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-020 IDLE->RESP on request acceptance; RESP->IDLE on response consumption without a new acceptance; RESP->RESP on consumption with simultaneous acceptance.
REQ-021 req_ready SHALL equal (!rsp_valid | rsp_ready), further gated per REQ-032.
REQ-022 Latency SHALL be one cycle: request accepted at edge k gives rsp_valid, rsp_taken, rsp_tag registered at edge k; visible in the cycle after edge k.
REQ-023 rsp_taken and rsp_tag SHALL remain stable while rsp_valid=1 and rsp_ready=0, including across flag_we writes.
REQ-024 Back-to-back accepted requests SHALL produce back-to-back responses with no bubble when rsp_ready=1.
REQ-025 taken_cnt SHALL increment by 1 on each consumed response with rsp_taken=1, wrapping from all-ones to 0.
REQ-026 flag_we SHALL be independent of the handshake; flags may update in any state.

Reset
REQ-027 On rst=0 the block SHALL immediately set: state IDLE, rsp_valid=0, rsp_taken=0, rsp_tag=0, flags_q=0, taken_cnt=0.
REQ-028 Reset asserted in RESP SHALL discard the pending response without incrementing taken_cnt.
REQ-029 req_ready SHALL be 0 while rst=0.
REQ-030 After rst deasserts, req_ready SHALL be 1 in the first cycle (subject to REQ-032).

Configuration
REQ-031 Macro FLAG_BYPASS_EN SHALL select flag forwarding.
REQ-032 Without FLAG_BYPASS_EN: req_ready SHALL additionally be forced 0 in any cycle with flag_we=1, so evaluation always uses committed flags_q.
REQ-033 With FLAG_BYPASS_EN: req_ready SHALL ignore flag_we; a request accepted in a cycle with flag_we=1 SHALL evaluate against {n_in,z_in,c_in,v_in}, otherwise against flags_q.

Verification
REQ-034 Reset then flag_we with Z=1, then req cond=0 (EQ), tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_taken=1, rsp_tag=3, taken_cnt=1 after consumption.
REQ-035 Flags N=1,V=0 committed; requests A (GE), B (LT), C (GT), D (LE) back-to-back, rsp_ready=1 -> rsp_taken 0,1,0,1 on consecutive cycles, taken_cnt=2.
REQ-036 Response pending with rsp_ready=0 for 3 cycles while flag_we toggles Z -> rsp_taken/rsp_tag unchanged, req_ready=0 throughout.
REQ-037 Flags Z=0 committed; req EQ with flag_we writing Z=1 same cycle -> without FLAG_BYPASS_EN req_ready=0 that cycle, accepted next cycle, rsp_taken=1; with FLAG_BYPASS_EN accepted same cycle, rsp_taken=1.
REQ-038 rst asserted while rsp_valid=1 -> rsp_valid, flags_q, taken_cnt all 0 immediately, no response delivered.
REQ-039 taken_cnt preloaded to all-ones via 2^CNT_W-1 taken AL responses, one more AL -> taken_cnt=0; F (NV) responses never increment.
